// File: rtl/sys_bus_resp_mux.sv
// rtl/sys_bus_resp_mux.sv - system bus response-return mux with bus-error and timeout handling
module sys_bus_resp_mux #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        en_mem_sfr,
    input  logic        en_mem_io,
    input  logic        en_mem_dfm,
    input  logic        en_mem_pfm,
    input  logic        en_mem_undef,
    input  logic        sfr_rdy,
    input  logic        io_rdy,
    input  logic        dfm_rdy,
    input  logic        pfm_rdy,
    input  logic [31:0] sfr_rdata,
    input  logic [31:0] io_rdata,
    input  logic [31:0] dfm_rdata,
    input  logic [31:0] pfm_rdata,
    output logic        req_ready,
    output logic [3:0]  sel_region,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [3:0]  en_vec;
    logic [3:0]  rdy_vec;
    logic        sel_legal;
    logic        rdy_hit;
    logic [31:0] sel_rdata;

    assign en_vec  = {en_mem_pfm, en_mem_dfm, en_mem_io, en_mem_sfr};
    assign rdy_vec = {pfm_rdy, dfm_rdy, io_rdy, sfr_rdy};

    // Legal only when exactly one defined region is enabled and the undef decode is clear
    assign sel_legal = !en_mem_undef && (en_vec != 4'd0) && ((en_vec & (en_vec - 4'd1)) == 4'd0);

    // Only the latched region's strobe matters; the others may be busy serving other masters
    assign rdy_hit = |(sel_q & rdy_vec);

    assign sel_rdata = ({32{sel_q[0]}} & sfr_rdata)
                     | ({32{sel_q[1]}} & io_rdata)
                     | ({32{sel_q[2]}} & dfm_rdata)
                     | ({32{sel_q[3]}} & pfm_rdata);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (sel_legal) begin
                        sel_d   = en_vec;
                        we_d    = req_we;
                        cnt_d   = 8'd0;
                        state_d = ST_WAIT;
                    end else begin
                        sel_d       = 4'd0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // A ready arriving on the final allowed cycle still beats the timeout
                if (rdy_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 32'd0 : sel_rdata;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                sel_d       = 4'd0;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                sel_d       = 4'd0;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 4'd0;
            we_q        <= 1'b0;
            cnt_q       <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_WAIT) || (state_q == ST_RESP);
    assign sel_region = sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_sys_bus_resp_mux.sv
// tb/tb_sys_bus_resp_mux.sv - scoreboard bench for sys_bus_resp_mux
module tb_sys_bus_resp_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic        en_mem_sfr, en_mem_io, en_mem_dfm, en_mem_pfm, en_mem_undef;
    logic        sfr_rdy, io_rdy, dfm_rdy, pfm_rdy;
    logic [31:0] sfr_rdata, io_rdata, dfm_rdata, pfm_rdata;
    logic        req_ready, busy, rsp_valid, rsp_err;
    logic [3:0]  sel_region;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sel;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sys_bus_resp_mux #(.TIMEOUT_CYC(16)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we),
        .en_mem_sfr(en_mem_sfr), .en_mem_io(en_mem_io), .en_mem_dfm(en_mem_dfm),
        .en_mem_pfm(en_mem_pfm), .en_mem_undef(en_mem_undef),
        .sfr_rdy(sfr_rdy), .io_rdy(io_rdy), .dfm_rdy(dfm_rdy), .pfm_rdy(pfm_rdy),
        .sfr_rdata(sfr_rdata), .io_rdata(io_rdata), .dfm_rdata(dfm_rdata), .pfm_rdata(pfm_rdata),
        .req_ready(req_ready), .sel_region(sel_region), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Every response strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h err=%b with no response expected", rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err || sel_region !== e.sel) begin
                    n_fail++;
                    $display("FAIL rsp_data: got rdata=%h err=%b sel=%b, expected rdata=%h err=%b sel=%b",
                             rsp_rdata, rsp_err, sel_region, e.rdata, e.err, e.sel);
                end
            end
        end
    end

    task automatic set_en(input logic [4:0] en);
        {en_mem_undef, en_mem_pfm, en_mem_dfm, en_mem_io, en_mem_sfr} = en;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_we = 1'b0;
        set_en(5'b00000);
        {pfm_rdy, dfm_rdy, io_rdy, sfr_rdy} = 4'b0000;
        sfr_rdata = 32'h0; io_rdata = 32'h0; dfm_rdata = 32'h0; pfm_rdata = 32'h0;
    endtask

    // en = {undef,pfm,dfm,io,sfr}; rdy_at = WAIT cycle index (1 = cycle after acceptance), 0 = never
    task automatic run_txn(input logic [4:0] en, input logic we, input int rdy_at, input logic [31:0] rd,
                           input logic tog_sfr, input int exp_lat, input logic exp_err, input string name);
        exp_t e;
        int   got;
        logic legal;
        legal   = !en[4] && ($countones(en[3:0]) == 1);
        e.sel   = legal ? en[3:0] : 4'b0000;
        e.err   = exp_err;
        e.rdata = (exp_err || we) ? 32'h0 : rd;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; set_en(en);
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; set_en(5'b00000);
        got = 0;
        for (int k = 1; k <= 40; k++) begin
            sfr_rdata = 32'h5F5F_0000 | k; io_rdata = 32'h1010_0000 | k;
            dfm_rdata = 32'hDFDF_0000 | k; pfm_rdata = 32'hBFBF_0000 | k;
            {pfm_rdy, dfm_rdy, io_rdy, sfr_rdy} = (k == rdy_at) ? en[3:0] : 4'b0000;
            if (k == rdy_at) begin
                if (en[0]) sfr_rdata = rd;
                if (en[1]) io_rdata  = rd;
                if (en[2]) dfm_rdata = rd;
                if (en[3]) pfm_rdata = rd;
            end
            if (tog_sfr) sfr_rdy = k[0];
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (busy !== 1'b1 || sel_region !== e.sel) begin
                    n_fail++;
                    $display("FAIL %s_first_cycle: busy=%b sel=%b, expected busy=1 sel=%b", name, busy, sel_region, e.sel);
                end
            end
            if (rsp_valid === 1'b1) begin
                got = k;
                break;
            end
            @(posedge clk); #1;
        end
        {pfm_rdy, dfm_rdy, io_rdy, sfr_rdy} = 4'b0000;
        n_checks++;
        if (got != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: response in cycle T+%0d, expected T+%0d (0 = none within bound)", name, got, exp_lat);
        end
        if (got == 0) void'(sb.pop_front());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || sel_region !== 4'h0 ||
            busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b rdata=%h err=%b sel=%b busy=%b ready=%b, expected 0 0 0 0 0 1",
                     rsp_valid, rsp_rdata, rsp_err, sel_region, busy, req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b busy=%b, expected ready=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_dfm_read();
        run_txn(5'b00100, 1'b0, 1, 32'hCAFE_0001, 1'b0, 2, 1'b0, "dfm_read");
    endtask

    task automatic test_bad_select();
        run_txn(5'b10000, 1'b0, 0, 32'h0, 1'b0, 1, 1'b1, "undef");
        run_txn(5'b00011, 1'b0, 0, 32'h0, 1'b0, 1, 1'b1, "multi_sel");
        run_txn(5'b00000, 1'b0, 0, 32'h0, 1'b0, 1, 1'b1, "no_sel");
        run_txn(5'b11000, 1'b0, 0, 32'h0, 1'b0, 1, 1'b1, "undef_pfm");
    endtask

    task automatic test_timeout();
        run_txn(5'b01000, 1'b0, 0,  32'h0,         1'b1, 17, 1'b1, "timeout");
        run_txn(5'b01000, 1'b0, 16, 32'h1234_5678, 1'b1, 17, 1'b0, "rdy_at_limit");
        run_txn(5'b00010, 1'b0, 2,  32'h0BAD_F00D, 1'b0, 3,  1'b0, "io_read");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; set_en(5'b00010);
        e.rdata = 32'h0; e.err = 1'b0; e.sel = 4'b0010;
        sb.push_back(e);
        @(posedge clk); #1;
        req_we = 1'b0; set_en(5'b00001);
        e.rdata = 32'hA5A5_0F0F; e.err = 1'b0; e.sel = 4'b0001;
        sb.push_back(e);
        for (int k = 1; k <= 5; k++) begin
            io_rdy = (k == 3); io_rdata = 32'hFFFF_0000;
            @(negedge clk);
            n_checks++;
            if (req_ready !== (k == 5)) begin
                n_fail++;
                $display("FAIL held_req_ready_T%0d: ready=%b, expected %b", k, req_ready, (k == 5));
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; set_en(5'b00000); io_rdy = 1'b0;
        sfr_rdy = 1'b1; sfr_rdata = 32'hA5A5_0F0F;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || sel_region !== 4'b0001) begin
            n_fail++;
            $display("FAIL held_req_accept: busy=%b sel=%b, expected busy=1 sel=0001", busy, sel_region);
        end
        @(posedge clk); #1;
        sfr_rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL held_req_rsp: rsp_valid=%b, expected 1", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        req_valid = 1'b1; set_en(5'b00100);
        @(posedge clk); #1;
        req_valid = 1'b0; set_en(5'b00000);
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || sel_region !== 4'h0 ||
            busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b rdata=%h err=%b sel=%b busy=%b ready=%b, expected 0 0 0 0 0 1",
                     rsp_valid, rsp_rdata, rsp_err, sel_region, busy, req_ready);
        end
        dfm_rdy = 1'b1; dfm_rdata = 32'h7777_7777;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; dfm_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL aborted_txn_%0d: rsp_valid=%b ready=%b, expected 0 1", k, rsp_valid, req_ready);
            end
        end
        run_txn(5'b00001, 1'b0, 1, 32'h5EED_0042, 1'b0, 2, 1'b0, "sfr_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected completion", n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dfm_read();
        test_bad_select();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bus_resp_mux.md
# sys_bus_resp_mux

Response-return path of the system bus, sitting between the memory regions and the CPU load/store port. On each accepted request it latches the one-hot region select produced by the memory-map decoder. It holds that select for the whole transaction, waits for the selected region's ready, and steers that region's read data back to the CPU as a single-cycle response. Undefined-region accesses, malformed selects and unanswered accesses are terminated with a bus-error response.

## Interface
- TIMEOUT_CYC, default 16: maximum number of WAIT cycles before an error response; legal range 1..255.
- sys_clk  in  1  system clock; all state changes on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request strobe; address is already decoded.
- req_we  in  1  request is a write (1) or read (0).
- en_mem_sfr, en_mem_io, en_mem_dfm, en_mem_pfm, en_mem_undef  in  1 each  region enables from the memory-map decoder, valid with req_valid.
- sfr_rdy, io_rdy, dfm_rdy, pfm_rdy  in  1 each  region access-complete strobes.
- sfr_rdata, io_rdata, dfm_rdata, pfm_rdata  in  32 each  region read data, valid with the matching rdy.
- req_ready  out  1  block can accept a request; high only in IDLE.
- sel_region  out  4  registered one-hot select {pfm,dfm,io,sfr}, held from acceptance until the response cycle ends.
- busy  out  1  high in WAIT or RESP.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  returned read data.
- rsp_err  out  1  bus error, qualified by rsp_valid.

## Operation
- **Reset values (asynchronous, sys_rst_n low):**
  - state IDLE, sel_region 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, timeout counter 0.
  - busy 0; req_ready 1 (both decoded from state).
- **Request acceptance:** a request is accepted when req_valid & req_ready are high at a clock edge.
  - Legal select: exactly one of the four defined enables is high and en_mem_undef is low. The block latches sel_region and req_we, clears the counter and goes to WAIT.
  - Otherwise (undef high, zero enables, or more than one enable): sel_region is set to 0, an error is latched and the block goes to RESP.
- **WAIT:** only the rdy of the latched region is sampled; rdy from unselected regions is ignored.
  - Selected rdy high: capture the matching rdata (reads) or 0 (writes), set rsp_err 0, go to RESP.
  - Selected rdy low: increment the counter. When the counter equals TIMEOUT_CYC-1 and rdy is still low, go to RESP with rsp_err 1 and rsp_rdata 0.
  - rdy in the same cycle as the timeout limit: rdy wins and no error is raised.
- **RESP:** rsp_valid is 1 for exactly one cycle. Then state returns to IDLE and sel_region, rsp_valid and rsp_err clear to 0. rsp_rdata holds its value until the next response.
- **Request outside IDLE:** req_valid while not in IDLE is ignored; the CPU must hold it until req_ready.
- **Reset mid-transaction:** the transaction is aborted with no response, and the block is in IDLE after reset release.
- **Counter width:** 8 bits, saturating logic not needed given the legal TIMEOUT_CYC range.

## Timing
- Request accepted at edge T. WAIT occupies cycle T+1 onward.
- Best-case response: rdy high in cycle T+1 gives rsp_valid in cycle T+2, so minimum latency is 2 cycles.
- Error select: rsp_valid with rsp_err in cycle T+1.
- Timeout: with no rdy, WAIT lasts TIMEOUT_CYC cycles and the error response is in cycle T+TIMEOUT_CYC+1.
- req_ready returns high in the cycle after RESP, giving a back-to-back request period of 3 cycles minimum.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert sys_rst_n low asynchronously mid-cycle -> outputs at reset values immediately; req_ready=1 after release.
- **DFM read:** en_mem_dfm=1, req_we=0; dfm_rdy=1 with dfm_rdata=32'hCAFE_0001 in cycle T+1 -> rsp_valid at T+2, rsp_rdata=32'hCAFE_0001, rsp_err=0, sel_region=4'b0100 through T+2.
- **Undefined region:** en_mem_undef=1 request -> rsp_valid and rsp_err=1 at T+1, rsp_rdata=0, sel_region=0. Repeat with en_mem_sfr=en_mem_io=1 -> same error response.
- **Timeout:** TIMEOUT_CYC=16, PFM read, pfm_rdy never asserted, sfr_rdy toggling every cycle -> no early response; rsp_err=1 at T+17. Same test with pfm_rdy in the 16th WAIT cycle -> rsp_err=0.
- **Write and held request:** IO write with io_rdy at T+3 -> rsp_valid at T+4, rsp_rdata=0. A second req_valid held high throughout is accepted at the T+5 edge.
- **Reset mid-WAIT:** assert reset two cycles into WAIT -> no rsp_valid ever produced. A new SFR read after release completes normally.
